// File: rtl/mem_dreq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_dreq_ctrl_if
// Purpose  : SRAM-like data-request bus between the MEM-stage access
//            controller (master) and the data memory system (slave).
//            Request phase: req/wr/size/addr/wstrb/wdata, accepted by addr_ok.
//            Data phase   : data_ok with rdata (read data valid on loads).
// Ports    : data_sram_req/wr/size/addr/wstrb/wdata  master -> slave
//            data_sram_addr_ok/data_ok/rdata         slave  -> master
// Revision : 1.0  initial release
// ============================================================================
interface mem_dreq_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            data_sram_req;
  logic            data_sram_wr;
  logic [1:0]      data_sram_size;
  logic [AW-1:0]   data_sram_addr;
  logic [DW/8-1:0] data_sram_wstrb;
  logic [DW-1:0]   data_sram_wdata;
  logic            data_sram_addr_ok;
  logic            data_sram_data_ok;
  logic [DW-1:0]   data_sram_rdata;

  modport master (
    output data_sram_req,
    output data_sram_wr,
    output data_sram_size,
    output data_sram_addr,
    output data_sram_wstrb,
    output data_sram_wdata,
    input  data_sram_addr_ok,
    input  data_sram_data_ok,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_req,
    input  data_sram_wr,
    input  data_sram_size,
    input  data_sram_addr,
    input  data_sram_wstrb,
    input  data_sram_wdata,
    output data_sram_addr_ok,
    output data_sram_data_ok,
    output data_sram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_dreq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_dreq_ctrl
// Purpose  : MEM-stage data-memory access controller feeding mem_wb_seg.
//            Turns a load/store in MEM into one req/addr_ok/data_ok
//            transaction, stalls the pipeline until the data phase is done,
//            drives mem_res and silently absorbs transactions that a
//            refresh (flush) killed while they were in flight.
// Ports    : clk, resetn            clock / async active-low reset
//            mem_valid/load/store   instruction qualifiers from MEM
//            mem_addr/wdata/lsV     address, lane-shifted store data, lanes
//            mem_alu_res            result of non-load instructions
//            stall, refresh         global pipeline stall / flush
//            mem_res, mem_stall     result to WB, memory-busy stall request
//            dbus                   data request bus (master side)
// Revision : 1.0  initial release
// ============================================================================
module mem_dreq_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  wire            clk,
  input  wire            resetn,
  input  wire            mem_valid,
  input  wire            mem_load,
  input  wire            mem_store,
  input  wire [AW-1:0]   mem_addr,
  input  wire [DW-1:0]   mem_wdata,
  input  wire [DW/8-1:0] mem_lsV,
  input  wire [DW-1:0]   mem_alu_res,
  input  wire            stall,
  input  wire            refresh,
  output logic [DW-1:0]  mem_res,
  output logic           mem_stall,
  mem_dreq_ctrl_if.master dbus
);

  localparam int LW = DW / 8;
  localparam int CW = $clog2(LW + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_wr;
  logic [1:0]      r_size;
  logic [AW-1:0]   r_addr;
  logic [LW-1:0]   r_wstrb;
  logic [DW-1:0]   r_wdata;
  logic            r_refresh_seen;
  logic [DW-1:0]   r_rdata;

  logic            w_start;
  logic [CW-1:0]   w_lane_cnt;
  logic [1:0]      w_size;
  logic [LW-1:0]   w_wstrb;

  // Gating with resetn keeps req/mem_stall low while reset is asserted,
  // even though the IDLE request path is purely combinational.
  assign w_start = resetn & mem_valid & (mem_load | mem_store) & ~refresh;
  assign w_wstrb = mem_store ? mem_lsV : '0;

  // Access size follows the number of enabled byte lanes (the mask is
  // already aligned upstream): one lane = byte, two = half, all = word.
  always_comb begin
    w_lane_cnt = '0;
    for (int i = 0; i < LW; i++) begin
      w_lane_cnt = w_lane_cnt + CW'(mem_lsV[i]);
    end
    if (w_lane_cnt == CW'(1))
      w_size = 2'd0;
    else if (w_lane_cnt == CW'(2))
      w_size = 2'd1;
    else
      w_size = 2'd2;
  end

  // Request bus: live inputs in the issue cycle, captured copy while the
  // address phase is stretched, all-zero otherwise.
  always_comb begin
    dbus.data_sram_req   = 1'b0;
    dbus.data_sram_wr    = 1'b0;
    dbus.data_sram_size  = 2'd0;
    dbus.data_sram_addr  = '0;
    dbus.data_sram_wstrb = '0;
    dbus.data_sram_wdata = '0;
    if (r_state == S_IDLE && w_start) begin
      dbus.data_sram_req   = 1'b1;
      dbus.data_sram_wr    = mem_store;
      dbus.data_sram_size  = w_size;
      dbus.data_sram_addr  = mem_addr;
      dbus.data_sram_wstrb = w_wstrb;
      dbus.data_sram_wdata = mem_wdata;
    end else if (r_state == S_REQ) begin
      dbus.data_sram_req   = 1'b1;
      dbus.data_sram_wr    = r_wr;
      dbus.data_sram_size  = r_size;
      dbus.data_sram_addr  = r_addr;
      dbus.data_sram_wstrb = r_wstrb;
      dbus.data_sram_wdata = r_wdata;
    end
  end

  always_comb begin
    mem_stall = 1'b0;
    case (r_state)
      S_IDLE:  mem_stall = w_start;
      S_REQ:   mem_stall = 1'b1;
      S_WAIT:  mem_stall = ~dbus.data_sram_data_ok;
      S_DRAIN: mem_stall = w_start;
      default: mem_stall = 1'b0;
    endcase
  end

  // Raw read word only; lane select and extension happen in WB.
  always_comb begin
    mem_res = mem_alu_res;
    if (r_state == S_WAIT && dbus.data_sram_data_ok && !r_wr)
      mem_res = dbus.data_sram_rdata;
    else if (r_state == S_HOLD && !r_wr)
      mem_res = r_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_wr           <= 1'b0;
      r_size         <= 2'd0;
      r_addr         <= '0;
      r_wstrb        <= '0;
      r_wdata        <= '0;
      r_refresh_seen <= 1'b0;
      r_rdata        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            // Captured even when accepted at once: r_wr tells WAIT/HOLD
            // whether the transaction is a load.
            r_wr           <= mem_store;
            r_size         <= w_size;
            r_addr         <= mem_addr;
            r_wstrb        <= w_wstrb;
            r_wdata        <= mem_wdata;
            r_refresh_seen <= 1'b0;
            r_state        <= dbus.data_sram_addr_ok ? S_WAIT : S_REQ;
          end
        end
        S_REQ: begin
          // The request cannot be withdrawn once raised; a flush only
          // marks it so its data phase is discarded later.
          if (refresh)
            r_refresh_seen <= 1'b1;
          if (dbus.data_sram_addr_ok)
            r_state <= (r_refresh_seen || refresh) ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (dbus.data_sram_data_ok) begin
            if (!r_wr)
              r_rdata <= dbus.data_sram_rdata;
            if (refresh)
              r_state <= S_IDLE;
            else if (stall)
              r_state <= S_HOLD;
            else
              r_state <= S_IDLE;
          end else if (refresh) begin
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (!stall || refresh)
            r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (dbus.data_sram_data_ok)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_dreq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_dreq_ctrl
// Purpose  : Randomised self-checking bench for mem_dreq_ctrl. A pipeline
//            driver presents instructions, a single-outstanding memory slave
//            answers the bus, a transaction-level reference model predicts
//            req/mem_stall/mem_res per cycle and queues expected requests
//            that a bus monitor pops at each address handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_dreq_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int N_CYC = 4000;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic resetn;
  logic mem_valid, mem_load, mem_store, stall, refresh;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_alu_res, mem_res;
  logic [3:0]    mem_lsV;
  logic          mem_stall;

  mem_dreq_ctrl_if #(.AW(AW), .DW(DW)) dbus ();

  mem_dreq_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem_valid  (mem_valid),
    .mem_load   (mem_load),
    .mem_store  (mem_store),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_lsV    (mem_lsV),
    .mem_alu_res(mem_alu_res),
    .stall      (stall),
    .refresh    (refresh),
    .mem_res    (mem_res),
    .mem_stall  (mem_stall),
    .dbus       (dbus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // current pipeline instruction
  logic        cur_valid, cur_load, cur_store;
  logic [31:0] cur_addr, cur_wdata, cur_alu;
  logic [3:0]  cur_lsv;

  // reference model state
  logic        txn_valid = 1'b0, txn_acc = 1'b0, txn_kill = 1'b0;
  logic        txn_wr = 1'b0, txn_load = 1'b0;
  logic [31:0] txn_addr = '0, txn_wdata = '0;
  logic [3:0]  txn_lsv = '0, txn_idx = '0;
  logic        hold_valid = 1'b0, hold_load = 1'b0;
  logic [31:0] hold_data = '0;
  logic        adv = 1'b0;
  logic        rst_done = 1'b0;
  logic [31:0] ref_mem [16];
  req_t        req_q [$];

  // slave state
  logic [31:0] sl_mem [16];
  logic        sl_busy = 1'b0, sl_load = 1'b0;
  logic [3:0]  sl_idx = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_size(input logic [3:0] lsv);
    case (lsv)
      4'b1111:          return 2'd2;
      4'b0011, 4'b1100: return 2'd1;
      default:          return 2'd0;
    endcase
  endfunction

  task automatic ref_write(input logic [3:0] idx, input logic [3:0] strb, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (strb[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic new_instr();
    int          k;
    int          off;
    logic [3:0]  one;
    logic [3:0]  two;
    k   = $urandom_range(0, 9);
    one = 4'b0001;
    two = 4'b0011;
    cur_valid = ($urandom_range(0, 9) != 0);
    cur_load  = (k < 4);
    cur_store = (k >= 4) && (k < 8);
    case ($urandom_range(0, 2))
      0: begin off = $urandom_range(0, 3);     cur_lsv = one << off; end
      1: begin off = 2 * $urandom_range(0, 1); cur_lsv = two << off; end
      default: begin off = 0;                  cur_lsv = 4'b1111;    end
    endcase
    cur_addr  = 32'h0000_1000 + 32'($urandom_range(0, 15)) * 32'd4 + 32'(off);
    cur_wdata = $urandom();
    cur_alu   = $urandom();
    mem_valid   = cur_valid;
    mem_load    = cur_load;
    mem_store   = cur_store;
    mem_addr    = cur_addr;
    mem_wdata   = cur_wdata;
    mem_lsV     = cur_lsv;
    mem_alu_res = cur_alu;
  endtask

  // ---------------- pipeline driver ----------------
  initial begin : driver
    resetn  = 1'b0;
    stall   = 1'b0;
    refresh = 1'b0;
    new_instr();
    cur_valid = 1'b1; cur_load = 1'b1; cur_store = 1'b0;
    mem_valid = 1'b1; mem_load = 1'b1; mem_store = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req",       128'(dbus.data_sram_req), 128'(1'b0));
    check("reset_mem_stall", 128'(mem_stall),          128'(1'b0));
    check("reset_mem_res",   128'(mem_res),            128'(cur_alu));
    resetn = 1'b1;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      #1;
      if (!resetn) resetn = 1'b1;
      if (adv) new_instr();
      stall   = ($urandom_range(0, 3) == 0);
      refresh = ($urandom_range(0, 11) == 0);
      #2;
      // asynchronous reset while a live transaction waits for its data
      if (!rst_done && cyc > 1000 && txn_valid && txn_acc && !txn_kill) begin
        resetn = 1'b0;
        #1;
        check("rst_wait_req",       128'(dbus.data_sram_req), 128'(1'b0));
        check("rst_wait_mem_stall", 128'(mem_stall),          128'(1'b0));
        check("rst_wait_mem_res",   128'(mem_res),            128'(cur_alu));
        rst_done = 1'b1;
      end
    end
    check("reset_mid_wait_exercised", 128'(rst_done), 128'(1'b1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- memory slave ----------------
  initial begin : slave
    dbus.data_sram_addr_ok = 1'b0;
    dbus.data_sram_data_ok = 1'b0;
    dbus.data_sram_rdata   = '0;
    for (int i = 0; i < 16; i++) begin
      sl_mem[i]  = $urandom();
      ref_mem[i] = sl_mem[i];
    end
    forever begin
      @(posedge clk);
      #2;
      dbus.data_sram_addr_ok = 1'b0;
      dbus.data_sram_data_ok = 1'b0;
      dbus.data_sram_rdata   = $urandom();
      if (sl_busy) begin
        if ($urandom_range(0, 2) == 0) begin
          dbus.data_sram_data_ok = 1'b1;
          if (sl_load) dbus.data_sram_rdata = sl_mem[sl_idx];
        end
      end else if (dbus.data_sram_req) begin
        dbus.data_sram_addr_ok = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      if (dbus.data_sram_data_ok) sl_busy = 1'b0;
      if (dbus.data_sram_req && dbus.data_sram_addr_ok) begin
        sl_busy = 1'b1;
        sl_idx  = dbus.data_sram_addr[5:2];
        sl_load = !dbus.data_sram_wr;
        if (dbus.data_sram_wr)
          for (int b = 0; b < 4; b++)
            if (dbus.data_sram_wstrb[b])
              sl_mem[sl_idx][8*b +: 8] = dbus.data_sram_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- reference model / per-cycle monitor ----------------
  initial begin : model
    logic        start, in_req, in_wait, in_drain, in_hold, idle, dok, aok;
    logic        e_req, e_stall;
    logic [31:0] e_res;
    req_t        r;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        txn_valid  = 1'b0;
        txn_acc    = 1'b0;
        txn_kill   = 1'b0;
        hold_valid = 1'b0;
        req_q.delete();
        adv = 1'b1;
      end else begin
        dok      = dbus.data_sram_data_ok;
        aok      = dbus.data_sram_addr_ok;
        start    = cur_valid && (cur_load || cur_store) && !refresh;
        in_req   = txn_valid && !txn_acc;
        in_wait  = txn_valid && txn_acc && !txn_kill;
        in_drain = txn_valid && txn_acc && txn_kill;
        in_hold  = hold_valid;
        idle     = !txn_valid && !hold_valid;

        e_req   = in_req || (idle && start);
        e_stall = in_req || (in_wait && !dok) || ((idle || in_drain) && start);
        if (in_wait && dok && txn_load) e_res = ref_mem[txn_idx];
        else if (in_hold && hold_load)  e_res = hold_data;
        else                            e_res = cur_alu;

        check("req",       128'(dbus.data_sram_req), 128'(e_req));
        check("mem_stall", 128'(mem_stall),          128'(e_stall));
        check("mem_res",   128'(mem_res),            128'(e_res));
        if (!dbus.data_sram_req)
          check("bus_zero_when_idle",
                128'({dbus.data_sram_wr, dbus.data_sram_size, dbus.data_sram_addr,
                      dbus.data_sram_wstrb, dbus.data_sram_wdata}), 128'(0));
        if (in_req)
          check("req_fields_stable",
                128'({dbus.data_sram_wr, dbus.data_sram_size, dbus.data_sram_addr, dbus.data_sram_wstrb}),
                128'({txn_wr, exp_size(txn_lsv), txn_addr, (txn_wr ? txn_lsv : 4'b0000)}));

        if (in_req) begin
          if (refresh) txn_kill = 1'b1;
          if (aok) begin
            txn_acc = 1'b1;
            if (txn_wr) ref_write(txn_idx, txn_lsv, txn_wdata);
          end
        end else if (in_wait) begin
          if (dok) begin
            txn_valid = 1'b0;
            if (!refresh && stall) begin
              hold_valid = 1'b1;
              hold_load  = txn_load;
              hold_data  = ref_mem[txn_idx];
            end
          end else if (refresh) begin
            txn_kill = 1'b1;
          end
        end else if (in_drain) begin
          if (dok) txn_valid = 1'b0;
        end else if (in_hold) begin
          if (!stall || refresh) hold_valid = 1'b0;
        end else if (start) begin
          txn_valid = 1'b1;
          txn_acc   = aok;
          txn_kill  = 1'b0;
          txn_wr    = cur_store;
          txn_load  = !cur_store;
          txn_addr  = cur_addr;
          txn_lsv   = cur_lsv;
          txn_wdata = cur_wdata;
          txn_idx   = cur_addr[5:2];
          r.wr    = cur_store;
          r.size  = exp_size(cur_lsv);
          r.addr  = cur_addr;
          r.wstrb = cur_store ? cur_lsv : 4'b0000;
          r.wdata = cur_wdata;
          req_q.push_back(r);
          if (aok && cur_store) ref_write(txn_idx, txn_lsv, txn_wdata);
        end
        adv = refresh || (!e_stall && !stall);
      end
    end
  end

  // ---------------- bus request scoreboard ----------------
  initial begin : bus_monitor
    req_t e;
    forever begin
      @(negedge clk);
      #1;
      if (resetn && dbus.data_sram_req && dbus.data_sram_addr_ok) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_request at %0t: actual addr %0h required no request", $time, dbus.data_sram_addr);
        end else begin
          e = req_q.pop_front();
          check("bus_wr",    128'(dbus.data_sram_wr),    128'(e.wr));
          check("bus_size",  128'(dbus.data_sram_size),  128'(e.size));
          check("bus_addr",  128'(dbus.data_sram_addr),  128'(e.addr));
          check("bus_wstrb", 128'(dbus.data_sram_wstrb), 128'(e.wstrb));
          if (e.wr)
            check("bus_wdata", 128'(dbus.data_sram_wdata), 128'(e.wdata));
        end
      end
    end
  end

endmodule
`default_nettype wire
